// File: rtl/coord_frame_parser.sv
// Byte-stream deframer: hunts for a sync byte, assembles NUM_COORDS big-endian words,
// optionally verifies a trailing XOR checksum, and publishes only complete good frames.
`timescale 1ns/1ps
module coord_frame_parser #(
    parameter int          NUM_COORDS      = 6,
    parameter int          BYTES_PER_COORD = 2,
    parameter logic [7:0]  SYNC_BYTE       = 8'h53,
    parameter bit          CHECKSUM_EN     = 1'b1,
    parameter int          TIMEOUT_CYCLES  = 1_000_000,
    localparam int         COORD_W         = 8 * BYTES_PER_COORD
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_COORDS*COORD_W-1:0]   coords,
    output logic                            frame_valid,
    output logic                            frame_error,
    output logic [15:0]                     err_count,
    output logic [1:0]                      state
);

    localparam int WIDX_W  = (NUM_COORDS > 1) ? $clog2(NUM_COORDS) : 1;
    localparam int SUB_W   = (BYTES_PER_COORD > 1) ? $clog2(BYTES_PER_COORD) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t                                 state_q, state_d;
    logic [NUM_COORDS-1:0][COORD_W-1:0]     shadow_q, shadow_d;
    logic [NUM_COORDS-1:0][COORD_W-1:0]     coords_q, coords_d;
    logic [WIDX_W-1:0]                      word_idx_q, word_idx_d;
    logic [SUB_W-1:0]                       sub_idx_q, sub_idx_d;
    logic [7:0]                             chk_q, chk_d;
    logic [TIMER_W-1:0]                     timer_q, timer_d;
    logic [15:0]                            err_q, err_d;
    logic                                   frame_valid_q, frame_valid_d;
    logic                                   frame_error_q, frame_error_d;

    logic                                   xfer;
    logic                                   last_byte;
    logic                                   timed_out;
    logic                                   drop;
    logic [COORD_W+7:0]                     shifted;

    // Ready is forced low while reset is held so nothing is consumed during reset.
    assign in_ready  = reset && (state_q != COMMIT);
    assign xfer      = in_valid && in_ready;
    assign last_byte = (word_idx_q == WIDX_W'(NUM_COORDS - 1)) &&
                       (sub_idx_q == SUB_W'(BYTES_PER_COORD - 1));
    assign timed_out = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign shifted   = {shadow_q[word_idx_q], in_data};

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        coords_d      = coords_q;
        word_idx_d    = word_idx_q;
        sub_idx_d     = sub_idx_q;
        chk_d         = chk_q;
        timer_d       = timer_q;
        err_d         = err_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        drop          = 1'b0;

        case (state_q)
            HUNT: begin
                timer_d = '0;
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d    = PAYLOAD;
                    word_idx_d = '0;
                    sub_idx_d  = '0;
                    chk_d      = '0;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    shadow_d[word_idx_q] = shifted[COORD_W-1:0];
                    chk_d   = chk_q ^ in_data;
                    timer_d = '0;
                    if (sub_idx_q == SUB_W'(BYTES_PER_COORD - 1)) begin
                        sub_idx_d  = '0;
                        word_idx_d = word_idx_q + 1'b1;
                    end else begin
                        sub_idx_d  = sub_idx_q + 1'b1;
                    end
                    // Without a checksum the last payload byte publishes directly.
                    if (last_byte) begin
                        if (CHECKSUM_EN) begin
                            state_d = CHECK;
                        end else begin
                            coords_d      = shadow_d;
                            frame_valid_d = 1'b1;
                            state_d       = COMMIT;
                        end
                    end
                end else if (timed_out) begin
                    drop = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if (xfer) begin
                    timer_d = '0;
                    if (in_data == chk_q) begin
                        coords_d      = shadow_q;
                        frame_valid_d = 1'b1;
                        state_d       = COMMIT;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (timed_out) begin
                    drop = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            COMMIT: state_d = HUNT;
            default: state_d = HUNT;
        endcase

        if (drop) begin
            frame_error_d = 1'b1;
            state_d       = HUNT;
            timer_d       = '0;
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= HUNT;
            shadow_q      <= '0;
            coords_q      <= '0;
            word_idx_q    <= '0;
            sub_idx_q     <= '0;
            chk_q         <= '0;
            timer_q       <= '0;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            coords_q      <= coords_d;
            word_idx_q    <= word_idx_d;
            sub_idx_q     <= sub_idx_d;
            chk_q         <= chk_d;
            timer_q       <= timer_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign coords      = coords_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign err_count   = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_coord_frame_parser.sv
// Randomised frame bench for coord_frame_parser: one checksummed 6x16-bit instance and
// one checksum-free 2x24-bit instance, both checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_coord_frame_parser;

    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]    in_data_a = '0, in_data_b = '0;
    logic          in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic          in_ready_a, in_ready_b;
    logic [95:0]   coords_a;
    logic [47:0]   coords_b;
    logic          fv_a, fv_b, fe_a, fe_b;
    logic [15:0]   err_a, err_b;
    logic [1:0]    state_a, state_b;

    coord_frame_parser #(
        .NUM_COORDS(6), .BYTES_PER_COORD(2), .SYNC_BYTE(8'h53),
        .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(TO)
    ) dut_a (
        .clock(clock), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .coords(coords_a), .frame_valid(fv_a),
        .frame_error(fe_a), .err_count(err_a), .state(state_a)
    );

    coord_frame_parser #(
        .NUM_COORDS(2), .BYTES_PER_COORD(3), .SYNC_BYTE(8'h53),
        .CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(TO)
    ) dut_b (
        .clock(clock), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .coords(coords_b), .frame_valid(fv_b),
        .frame_error(fe_b), .err_count(err_b), .state(state_b)
    );

    int            errors = 0;
    int            checks = 0;
    logic [127:0]  m_coords [2];
    int            m_err [2];
    logic [7:0]    pl [16];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] get_coords(input bit sel);
        return sel ? 128'(coords_b) : 128'(coords_a);
    endfunction
    function automatic logic [127:0] get_fv(input bit sel);
        return sel ? 128'(fv_b) : 128'(fv_a);
    endfunction
    function automatic logic [127:0] get_fe(input bit sel);
        return sel ? 128'(fe_b) : 128'(fe_a);
    endfunction
    function automatic logic [127:0] get_err(input bit sel);
        return sel ? 128'(err_b) : 128'(err_a);
    endfunction
    function automatic logic [127:0] get_state(input bit sel);
        return sel ? 128'(state_b) : 128'(state_a);
    endfunction
    function automatic logic [127:0] get_ready(input bit sel);
        return sel ? 128'(in_ready_b) : 128'(in_ready_a);
    endfunction

    task automatic drive(input bit sel, input bit v, input logic [7:0] d);
        if (sel) begin in_valid_b = v; in_data_b = d; end
        else     begin in_valid_a = v; in_data_a = d; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Offers a byte and holds it until accepted; reports how many cycles it waited.
    task automatic send_byte(input bit sel, input logic [7:0] d, output int waits);
        drive(sel, 1'b1, d);
        waits = 0;
        while (get_ready(sel) != 128'd1) begin
            @(posedge clock); #1;
            waits++;
            if (waits > 8) begin
                check_val("ready_bound", get_ready(sel), 128'd1);
                break;
            end
        end
        @(posedge clock); #1;
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic run_frame(input bit sel, input logic [7:0] chk_xor, input bit gaps,
                             input bit post, output int sync_waits);
        int n, bpc, nb, wbits, waits;
        bit use_chk, good;
        logic [7:0] x, ck;
        logic [31:0] word;
        logic [127:0] expc;
        n = sel ? 2 : 6;
        bpc = sel ? 3 : 2;
        wbits = 8 * bpc;
        nb = n * bpc;
        use_chk = !sel;
        x = 8'h00;
        for (int i = 0; i < nb; i++) x = x ^ pl[i];
        ck = x ^ chk_xor;
        good = !use_chk || (chk_xor == 8'h00);

        send_byte(sel, 8'h53, sync_waits);
        for (int i = 0; i < nb; i++) begin
            if (gaps) idle(int'($urandom_range(0, 3)));
            if (i == nb - 1 && !use_chk) begin
                check_val("no_leak", get_coords(sel), m_coords[sel]);
            end
            send_byte(sel, pl[i], waits);
            check_val("data_wait", 128'(waits), 128'd0);
        end
        if (use_chk) begin
            if (gaps) idle(int'($urandom_range(0, 3)));
            check_val("no_leak", get_coords(sel), m_coords[sel]);
            send_byte(sel, ck, waits);
            check_val("chk_wait", 128'(waits), 128'd0);
        end

        if (good) begin
            expc = '0;
            for (int k = 0; k < n; k++) begin
                word = '0;
                for (int j = 0; j < bpc; j++) word = (word << 8) | 32'(pl[k*bpc + j]);
                expc = expc | (128'(word) << (k * wbits));
            end
            m_coords[sel] = expc;
        end else begin
            m_err[sel] = (m_err[sel] < 65535) ? m_err[sel] + 1 : 65535;
        end

        check_val("frame_valid", get_fv(sel), 128'(good));
        check_val("frame_error", get_fe(sel), 128'(!good));
        check_val("coords", get_coords(sel), m_coords[sel]);
        check_val("err_count", get_err(sel), 128'(m_err[sel]));
        check_val("state_after", get_state(sel), good ? 128'd3 : 128'd0);
        check_val("ready_after", get_ready(sel), good ? 128'd0 : 128'd1);
        if (post) begin
            @(posedge clock); #1;
            check_val("fv_pulse", get_fv(sel), 128'd0);
            check_val("fe_pulse", get_fe(sel), 128'd0);
            check_val("state_hunt", get_state(sel), 128'd0);
            check_val("ready_hunt", get_ready(sel), 128'd1);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time %0t exceeded limit 1ms", $time);
        $fatal(1);
    end

    initial begin
        int w, nfire;
        logic [7:0] g;
        m_coords[0] = '0; m_coords[1] = '0;
        m_err[0] = 0;     m_err[1] = 0;

        // Reset values while reset is held.
        repeat (3) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_val("rst_ready", get_ready(1'(s)), 128'd0);
            check_val("rst_state", get_state(1'(s)), 128'd0);
            check_val("rst_coords", get_coords(1'(s)), 128'd0);
            check_val("rst_fv", get_fv(1'(s)), 128'd0);
            check_val("rst_fe", get_fe(1'(s)), 128'd0);
            check_val("rst_err", get_err(1'(s)), 128'd0);
        end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // Known good frame.
        for (int i = 0; i < 16; i++) pl[i] = 8'h00;
        pl[0] = 8'h01; pl[1] = 8'h02;
        run_frame(1'b0, 8'h00, 1'b0, 1'b1, w);
        $display("frame A spec good: coords=%0h err=%0d", coords_a, err_a);
        check_val("spec_coords", get_coords(1'b0), 128'h0102);

        // Same frame with checksum 04 instead of 03.
        run_frame(1'b0, 8'h07, 1'b0, 1'b1, w);
        $display("frame A spec bad chk: coords=%0h err=%0d", coords_a, err_a);
        check_val("spec_err1", get_err(1'b0), 128'd1);

        for (int i = 0; i < 12; i++) pl[i] = 8'($urandom_range(0, 255));
        run_frame(1'b0, 8'h00, 1'b1, 1'b1, w);
        $display("frame A good after bad: coords=%0h", coords_a);

        // Garbage, then a frame carrying the sync value as payload.
        send_byte(1'b0, 8'hAA, w);
        send_byte(1'b0, 8'h00, w);
        send_byte(1'b0, 8'hFF, w);
        check_val("garbage_hunt", get_state(1'b0), 128'd0);
        for (int i = 0; i < 12; i++) pl[i] = 8'($urandom_range(0, 255));
        pl[3] = 8'h53;
        run_frame(1'b0, 8'h00, 1'b0, 1'b1, w);
        $display("frame A garbage+sync-in-payload: coords=%0h", coords_a);

        // Timeout after a partial frame.
        send_byte(1'b0, 8'h53, w);
        for (int i = 0; i < 5; i++) send_byte(1'b0, 8'($urandom_range(0, 255)), w);
        nfire = 0;
        for (int c = 1; c <= 2 * TO; c++) begin
            @(posedge clock); #1;
            if (fe_a) begin nfire = c; break; end
        end
        m_err[0] = m_err[0] + 1;
        $display("frame A timeout: fired after %0d idle cycles", nfire);
        check_val("timeout_cycle", 128'(nfire), 128'(TO));
        check_val("timeout_state", get_state(1'b0), 128'd0);
        check_val("timeout_coords", get_coords(1'b0), m_coords[0]);
        check_val("timeout_err", get_err(1'b0), 128'(m_err[0]));

        // Reset in the middle of a payload.
        send_byte(1'b0, 8'h53, w);
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'($urandom_range(0, 255)), w);
        #2 reset = 1'b0;
        #1;
        m_coords[0] = '0; m_coords[1] = '0;
        m_err[0] = 0;     m_err[1] = 0;
        check_val("midrst_ready", get_ready(1'b0), 128'd0);
        check_val("midrst_state", get_state(1'b0), 128'd0);
        check_val("midrst_coords", get_coords(1'b0), 128'd0);
        check_val("midrst_err", get_err(1'b0), 128'd0);
        check_val("midrst_fv", get_fv(1'b0), 128'd0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 12; i++) pl[i] = 8'($urandom_range(0, 255));
        run_frame(1'b0, 8'h00, 1'b0, 1'b1, w);
        $display("frame A after reset: coords=%0h err=%0d", coords_a, err_a);

        // Random traffic on the checksummed instance.
        for (int f = 0; f < 25; f++) begin
            for (int gi = 0; gi < int'($urandom_range(0, 2)); gi++) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'h53) g = 8'h54;
                send_byte(1'b0, g, w);
            end
            for (int i = 0; i < 12; i++) pl[i] = 8'($urandom_range(0, 255));
            g = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(1'b0, g, 1'b1, 1'($urandom_range(0, 1)), w);
            $display("frame A rnd %0d: chk_xor=%0h coords=%0h err=%0d", f, g, coords_a, err_a);
        end

        // Checksum-free instance, back-to-back frames.
        pl[0] = 8'hAB; pl[1] = 8'hCD; pl[2] = 8'hEF;
        pl[3] = 8'h12; pl[4] = 8'h34; pl[5] = 8'h56;
        run_frame(1'b1, 8'h00, 1'b0, 1'b0, w);
        $display("frame B spec first: coords=%0h", coords_b);
        check_val("b_spec_coords", get_coords(1'b1), 128'h123456ABCDEF);
        for (int i = 0; i < 6; i++) pl[i] = 8'($urandom_range(0, 255));
        run_frame(1'b1, 8'h00, 1'b0, 1'b1, w);
        $display("frame B back-to-back: coords=%0h sync_waits=%0d", coords_b, w);
        check_val("b2b_sync_wait", 128'(w), 128'd1);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 6; i++) pl[i] = 8'($urandom_range(0, 255));
            run_frame(1'b1, 8'h00, 1'b1, 1'($urandom_range(0, 1)), w);
            $display("frame B rnd %0d: coords=%0h", f, coords_b);
        end
        check_val("b_err_final", get_err(1'b1), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
